// File: rtl/hci_input_conditioner.sv
// Multi-channel HCI input conditioner: synchroniser, stable-count debouncer,
// registered edge pulses and optional per-channel auto-repeat.
module hci_input_conditioner #(
  parameter int       NUM_CH          = 5,
  parameter int       SYNC_STAGES     = 2,
  parameter int       DEBOUNCE_CYCLES = 1000000,
  parameter int       REPEAT_DELAY    = 50000000,
  parameter int       REPEAT_RATE     = 10000000,
  parameter logic     RESET_LEVEL     = 1'b0
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic [NUM_CH-1:0] repeat_en,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] press,
  output logic              any_press
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RPT
  } rpt_state_e;

  logic [NUM_CH-1:0] r_sync [SYNC_STAGES];

  // NOTE: the synchroniser array is small and must start at a known level,
  // so every stage is reset, unlike a storage RAM which would be left unreset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= {NUM_CH{RESET_LEVEL}};
    end else begin
      r_sync[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic          w_s;
    logic          w_accept;
    logic          w_rise_evt;
    logic          w_fall_evt;
    logic [DW-1:0] r_db_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          r_press;
    rpt_state_e    r_state;
    rpt_state_e    w_state_nxt;
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_nxt;
    logic          w_rpt_pulse;

    assign w_s        = r_sync[SYNC_STAGES-1][c];
    assign w_accept   = (w_s != r_level) && (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign w_rise_evt = w_accept & w_s;
    assign w_fall_evt = w_accept & ~w_s;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        r_level  <= RESET_LEVEL;
        r_db_cnt <= '0;
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_press  <= 1'b0;
      end else begin
        r_rise  <= w_rise_evt;
        r_fall  <= w_fall_evt;
        r_press <= w_rise_evt | w_rpt_pulse;
        if (w_s == r_level) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_level  <= w_s;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        r_state <= IDLE;
        r_rcnt  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_rcnt  <= w_rcnt_nxt;
      end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_rpt_pulse = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise_evt && repeat_en[c]) begin
            w_state_nxt = DELAY;
            w_rcnt_nxt  = '0;
          end
        end
        DELAY, RPT: begin
          // Exit wins over a pulse due on the same edge.
          if (w_fall_evt || !repeat_en[c]) begin
            w_state_nxt = IDLE;
            w_rcnt_nxt  = '0;
          end else if (r_rcnt == ((r_state == DELAY) ? RW'(REPEAT_DELAY - 1)
                                                     : RW'(REPEAT_RATE - 1))) begin
            w_rpt_pulse = 1'b1;
            w_state_nxt = RPT;
            w_rcnt_nxt  = '0;
          end else begin
            w_rcnt_nxt  = r_rcnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = '0;
        end
      endcase
    end

    assign level[c] = r_level;
    assign rise[c]  = r_rise;
    assign fall[c]  = r_fall;
    assign press[c] = r_press;
  end

  assign any_press = |press;

endmodule

// File: tb/tb_hci_input_conditioner.sv
// Directed bench for hci_input_conditioner: expected edge/press events are
// queued as stimulus is driven and matched as the DUT emits them.
module tb_hci_input_conditioner;

  localparam int N = 5;

  logic         clk;
  logic         reset_;
  logic [N-1:0] raw_in;
  logic [N-1:0] repeat_en;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] press;
  logic         any_press;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] press;
  } ev_t;

  ev_t sb[$];

  hci_input_conditioner #(
    .NUM_CH(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_RATE(3), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .reset_(reset_), .raw_in(raw_in), .repeat_en(repeat_en),
    .level(level), .rise(rise), .fall(fall), .press(press), .any_press(any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sorted insert; events of several channels in one cycle merge into one entry.
  task automatic push(input int c, input logic [N-1:0] r, input logic [N-1:0] f,
                      input logic [N-1:0] p);
    int idx  = sb.size();
    bit done = 1'b0;
    for (int i = 0; i < sb.size() && !done; i++) begin
      if (sb[i].cyc == 32'(c)) begin
        sb[i].rise  = sb[i].rise | r;
        sb[i].fall  = sb[i].fall | f;
        sb[i].press = sb[i].press | p;
        done = 1'b1;
      end else if (sb[i].cyc > 32'(c)) begin
        idx  = i;
        done = 1'b1;
      end
    end
    if (!(done && idx == sb.size()) && !(done && sb.size() > 0 && idx < sb.size()
        && sb[idx].cyc == 32'(c)))
      sb.insert(idx, '{cyc: 32'(c), rise: r, fall: f, press: p});
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if ((rise | fall | press) != '0 || any_press) begin
      ev_t e;
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{cyc: '1, rise: '0, fall: '0, press: '0};
      check("event", 64'({32'(cyc), rise, fall, press, any_press}),
                     64'({e.cyc, e.rise, e.fall, e.press, |e.press}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    int r;
    reset_    = 1'b0;
    raw_in    = '0;
    repeat_en = '0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({level, rise, fall, press, any_press}), 64'(0));
    reset_ = 1'b1;
    wait_cyc(cyc + 3);

    // Clean press/release on ch0, repeat disabled.
    n = cyc;
    raw_in[0] = 1'b1;
    push(n + 6, 5'b00001, 5'b00000, 5'b00001);
    wait_cyc(n + 5);
    check("clean_level_pre", 64'(level[0]), 64'(0));
    wait_cyc(n + 6);
    check("clean_level_post", 64'(level[0]), 64'(1));
    wait_cyc(n + 20);
    raw_in[0] = 1'b0;
    push(n + 26, 5'b00000, 5'b00001, 5'b00000);
    wait_cyc(n + 25);
    check("clean_release_pre", 64'(level[0]), 64'(1));
    wait_cyc(n + 26);
    check("clean_release_post", 64'(level[0]), 64'(0));
    wait_cyc(n + 35);

    // Bounce on ch1: toggles every 3 cycles, never long enough to accept.
    n = cyc;
    for (int k = 0; k < 30; k++) begin
      wait_cyc(n + k);
      if (k % 3 == 0) raw_in[1] = ~raw_in[1];
      check("bounce_level", 64'(level[1]), 64'(0));
    end
    raw_in[1] = 1'b0;
    wait_cyc(n + 40);
    check("bounce_settled", 64'(level[1]), 64'(0));

    // Auto-repeat on ch1, held 40 cycles; the pulse due on the fall edge is dropped.
    repeat_en[1] = 1'b1;
    n = cyc;
    raw_in[1] = 1'b1;
    push(n + 6, 5'b00010, 5'b00000, 5'b00010);
    for (int t = n + 16; t <= n + 43; t += 3) push(t, 5'b00000, 5'b00000, 5'b00010);
    wait_cyc(n + 40);
    raw_in[1] = 1'b0;
    push(n + 46, 5'b00000, 5'b00010, 5'b00000);
    wait_cyc(n + 60);
    repeat_en[1] = 1'b0;
    check("repeat_released", 64'(level[1]), 64'(0));

    // Simultaneous press on ch2 and ch4.
    n = cyc;
    raw_in[2] = 1'b1;
    raw_in[4] = 1'b1;
    push(n + 6, 5'b10100, 5'b00000, 5'b10100);
    wait_cyc(n + 6);
    check("simul_any_on", 64'(any_press), 64'(1));
    wait_cyc(n + 7);
    check("simul_any_off", 64'(any_press), 64'(0));
    wait_cyc(n + 15);
    raw_in[2] = 1'b0;
    raw_in[4] = 1'b0;
    push(n + 21, 5'b00000, 5'b10100, 5'b00000);
    wait_cyc(n + 30);

    // Reset with ch1 in RPT and ch3 mid-debounce (counter = 2).
    repeat_en[1] = 1'b1;
    n = cyc;
    raw_in[1] = 1'b1;
    push(n + 6, 5'b00010, 5'b00000, 5'b00010);
    push(n + 16, 5'b00000, 5'b00000, 5'b00010);
    push(n + 19, 5'b00000, 5'b00000, 5'b00010);
    push(n + 22, 5'b00000, 5'b00000, 5'b00010);
    wait_cyc(n + 20);
    raw_in[3] = 1'b1;
    wait_cyc(n + 24);
    check("pre_reset_level", 64'(level), 64'(5'b00010));
    #2 reset_ = 1'b0;
    #1 check("reset_async", 64'({level, rise, fall, press, any_press}), 64'(0));
    raw_in[1] = 1'b0;
    wait_cyc(n + 27);
    reset_ = 1'b1;
    r = cyc;
    push(r + 6, 5'b01000, 5'b00000, 5'b01000);
    wait_cyc(r + 5);
    check("post_reset_pre", 64'(level[3]), 64'(0));
    wait_cyc(r + 6);
    check("post_reset_post", 64'(level[3]), 64'(1));
    wait_cyc(r + 40);
    check("post_reset_ch1", 64'(level[1]), 64'(0));
    raw_in[3] = 1'b0;
    push(cyc + 6, 5'b00000, 5'b01000, 5'b00000);
    repeat_en[1] = 1'b0;
    wait_cyc(cyc + 15);

    // Repeat disabled in RPT one cycle before a due pulse, then re-enabled.
    repeat_en[1] = 1'b1;
    n = cyc;
    raw_in[1] = 1'b1;
    push(n + 6, 5'b00010, 5'b00000, 5'b00010);
    push(n + 16, 5'b00000, 5'b00000, 5'b00010);
    push(n + 19, 5'b00000, 5'b00000, 5'b00010);
    wait_cyc(n + 21);
    repeat_en[1] = 1'b0;
    wait_cyc(n + 25);
    repeat_en[1] = 1'b1;
    wait_cyc(n + 30);
    check("disable_level_held", 64'(level[1]), 64'(1));
    wait_cyc(n + 45);
    check("reenable_level_held", 64'(level[1]), 64'(1));
    raw_in[1] = 1'b0;
    push(n + 51, 5'b00000, 5'b00010, 5'b00000);
    wait_cyc(n + 60);
    repeat_en = '0;

    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hci_input_conditioner.md
Name: hci_input_conditioner

Overview:
- Parametrised, multi-channel successor to the per-button debouncers on the HCI inputs (buttons and switches).
- Each channel gets:
  - a synchroniser;
  - a stable-count debouncer;
  - registered rise and fall edge pulses;
  - an optional per-channel auto-repeat.
- Sits between the board pins and the camera driver and segment logic. One instance replaces N separate debouncers.

Parameters:
NUM_CH, 5, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (>=1)
REPEAT_DELAY, 50000000, cycles from accepted press to first auto-repeat pulse (>=1)
REPEAT_RATE, 10000000, cycles between subsequent auto-repeat pulses (>=1)
RESET_LEVEL, 1'b0, value loaded into synchroniser and debounced level at reset

Ports:
clk  input  1  system clock; all logic on rising edge
reset_  input  1  asynchronous, active-low reset
raw_in  input  NUM_CH  raw asynchronous pin levels
repeat_en  input  NUM_CH  per-channel auto-repeat enable, synchronous to clk
level  output  NUM_CH  debounced level
rise  output  NUM_CH  1-cycle pulse on accepted 0->1
fall  output  NUM_CH  1-cycle pulse on accepted 1->0
press  output  NUM_CH  rise OR auto-repeat pulse, 1 cycle
any_press  output  1  OR-reduction of press, same cycle

Behaviour:
- Reset (reset_ low, asynchronous):
  - synchroniser flops and level go to RESET_LEVEL;
  - all counters go to 0;
  - repeat FSM goes to IDLE;
  - rise, fall, press and any_press go to 0.
- Reset can assert at any time, including mid-debounce or mid-repeat. On release, a channel whose raw_in equals RESET_LEVEL produces no edge.
- Synchroniser: SYNC_STAGES flops per channel. The debouncer sees s = last stage.
- Debounce, per channel:
  - counter width is $clog2(DEBOUNCE_CYCLES+1);
  - if s == level, the counter goes to 0;
  - otherwise the counter increments;
  - on the edge where the counter equals DEBOUNCE_CYCLES-1 and s != level still holds: level <= s and the counter goes to 0.
- Any single-cycle return of s to level restarts the count from 0.
- Latency: raw change held stable -> level updates SYNC_STAGES + DEBOUNCE_CYCLES edges later.
- Edge pulses are registered at the same edge as the level update, so they are high during the first cycle level shows its new value.
  - rise = new level 1; fall = new level 0.
  - Each pulse lasts exactly 1 cycle.
- Repeat FSM, per channel, states IDLE, DELAY, RPT; repeat counter width sized for max(REPEAT_DELAY, REPEAT_RATE).
  - IDLE: on a rise with repeat_en=1 -> DELAY, counter 0.
  - DELAY: counter increments. At REPEAT_DELAY-1 -> repeat pulse, counter 0, go to RPT.
  - RPT: counter increments. At REPEAT_RATE-1 -> repeat pulse, counter 0, stay in RPT.
  - DELAY or RPT with fall or repeat_en=0 -> IDLE next edge, counter 0. No repeat pulse is issued on that edge; exit has priority over a pulse.
  - Re-asserting repeat_en while held does not restart repeat; a new rise is required.
- Output combining:
  - press = rise | repeat pulse, registered, 1 cycle.
  - any_press is combinational OR of the registered press.
- Channels are fully independent. Simultaneous events on several channels all appear in the same cycle.
- repeat_en changes while the channel is IDLE have no effect.

Test Plan:
(Bench parameters: NUM_CH=5, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, RESET_LEVEL=0.)
- Clean press, ch0 (repeat_en=0): raw_in[0] 0->1 before edge 0, held.
  - Required: level[0]=1 from edge 6; rise[0]=press[0]=any_press=1 for exactly cycle 6; no further press.
  - Release after 20 cycles -> fall[0] 1 cycle, 6 edges later.
- Bounce, ch1: raw_in[1] toggles every 3 cycles for 30 cycles, then returns to 0.
  - Required: level[1] stays 0; rise, fall and press all stay 0 throughout.
- Auto-repeat, ch1 (repeat_en[1]=1), held 40 cycles: rise at T.
  - Required: press[1] at T, T+10, T+13, T+16, ...
  - After release: fall pulse, and no press after the fall edge.
- Simultaneous, ch2 and ch4: pressed in the same cycle.
  - Required: press[2] and press[4] high in the same single cycle; any_press high for that one cycle only.
- Reset mid-operation: ch3 mid-debounce (counter=2) and ch1 in RPT; assert reset_ asynchronously.
  - Required: all outputs 0 immediately.
  - After release with raw_in[3] still 1: level[3]=1 exactly 6 edges after release; ch1 is IDLE and issues no repeat until a new rise.
- Repeat disable, ch1: repeat_en[1] deasserted in RPT, one cycle before a due pulse.
  - Required: no pulse; level stays 1; re-asserting repeat_en[1] while held produces no press.
